// File: rtl/pipe_stall_ctrl.sv
// Hazard/flush sequencer for the 5-stage pipeline: merges per-stage stall requests,
// schedules the fixed-latency EX divider and defers exception redirects behind fetches.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_if,
    input  logic        req_id,
    input  logic        ex_div_req,
    input  logic        req_mem,
    input  logic        except_valid,
    input  logic [31:0] except_pc,
    input  logic        if_busy,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        redirect_pending,
    output logic        in_delayslot_hold,
    output logic        div_start,
    output logic        div_valid
);

    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_e;
    typedef enum logic       {F_IDLE, F_WAIT}        fl_state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_e       div_q, div_d;
    fl_state_e        fl_q, fl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;

    logic        flush_c, wait_c, start_c, busy_c, valid_c, hold_c;
    logic [31:0] flush_pc_c;
    logic [4:0]  stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= D_IDLE;
            fl_q  <= F_IDLE;
            cnt_q <= '0;
            pc_q  <= '0;
        end else begin
            div_q <= div_d;
            fl_q  <= fl_d;
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
        end
    end

    // Redirect sequencing; wait_c covers both the latching cycle and the whole wait.
    always_comb begin
        fl_d       = fl_q;
        pc_d       = pc_q;
        flush_c    = 1'b0;
        flush_pc_c = '0;
        wait_c     = 1'b0;
        case (fl_q)
            F_IDLE: begin
                if (except_valid) begin
                    if (if_busy) begin
                        wait_c = 1'b1;
                        pc_d   = except_pc;
                        fl_d   = F_WAIT;
                    end else begin
                        flush_c    = 1'b1;
                        flush_pc_c = except_pc;
                    end
                end
            end
            F_WAIT: begin
                wait_c = 1'b1;
                if (!if_busy) begin
                    flush_c    = 1'b1;
                    flush_pc_c = pc_q;
                    fl_d       = F_IDLE;
                end
            end
            default: fl_d = F_IDLE;
        endcase
    end

    // Divider schedule: the result is presented DIV_CYCLES cycles after div_start.
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        start_c = 1'b0;
        busy_c  = 1'b0;
        valid_c = 1'b0;
        case (div_q)
            D_IDLE: begin
                if (ex_div_req && !req_mem && !flush_c) begin
                    start_c = 1'b1;
                    busy_c  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    div_d   = D_RUN;
                end
            end
            D_RUN: begin
                busy_c = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    div_d = D_DONE;
                end
            end
            D_DONE: begin
                valid_c = 1'b1;
                if (!req_mem) begin
                    div_d = D_IDLE;
                end
            end
            default: div_d = D_IDLE;
        endcase
        if (flush_c) begin
            div_d = D_IDLE;
            cnt_d = '0;
        end
    end

    always_comb begin
        stall_c = 5'b00000;
        if (wait_c || req_mem) begin
            stall_c = 5'b11110;
        end else if (busy_c) begin
            stall_c = 5'b11100;
        end else if (req_id) begin
            stall_c = 5'b11000;
        end else if (req_if) begin
            stall_c = 5'b10000;
        end
        if (flush_c) begin
            stall_c = 5'b00000;
        end
        hold_c = stall_c[4] && !stall_c[3] && !flush_c;
    end

    // Outputs are forced low for as long as reset is held, regardless of inputs.
    always_comb begin
        stall             = '0;
        flush             = 1'b0;
        flush_pc          = '0;
        redirect_pending  = 1'b0;
        in_delayslot_hold = 1'b0;
        div_start         = 1'b0;
        div_valid         = 1'b0;
        if (rst) begin
            stall             = stall_c;
            flush             = flush_c;
            flush_pc          = flush_pc_c;
            redirect_pending  = wait_c;
            in_delayslot_hold = hold_c;
            div_start         = start_c;
            div_valid         = valid_c;
        end
    end

endmodule
